exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_exec_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/branch/jump/load-store ops plus an optional
// iterative shift-add multiplier. All outputs are registered.
module exec_unit #(
  parameter int unsigned XLEN   = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [4:0]        op,
  input  logic              use_imm,
  input  logic [1:0]        size,
  input  logic [XLEN-1:0]   x_rs1,
  input  logic [XLEN-1:0]   x_rs2,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic              flush,
  output logic              ex_rd_vld,
  output logic [XLEN-1:0]   ex_rd,
  output logic              ex_jmp_vld,
  output logic [XLEN-1:0]   ex_jmp_addr,
  output logic [XLEN-1:0]   ex_mem_addr,
  output logic [XLEN/8-1:0] ex_mem_rden,
  output logic [XLEN/8-1:0] ex_mem_wren,
  output logic [XLEN-1:0]   ex_mem_wrdata,
  output logic              ex_misalign
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d, mul_sum;

  logic            rd_vld_d, jmp_vld_d, mis_d;
  logic [XLEN-1:0] rd_d, jmp_addr_d, mem_addr_d, wrdata_d;
  logic [NB-1:0]   rden_d, wren_d;

  logic            accept;
  logic [XLEN-1:0] opb, ls_addr;
  logic [OW-1:0]   ls_off;
  logic            ls_mis;
  logic [NB-1:0]   lane_mask;
  logic [SW-1:0]   shamt;
  logic            br_lt, br_eq;

  assign in_rdy = (state_q == IDLE);

  // Operand selection, address/lane decode and compare helpers
  always_comb begin
    accept  = in_vld && in_rdy && !flush;
    opb     = use_imm ? imm : x_rs2;
    shamt   = opb[SW-1:0];
    ls_addr = x_rs1 + imm;
    ls_off  = ls_addr[OW-1:0];
    br_lt   = $signed(x_rs1) < $signed(x_rs2);
    br_eq   = (x_rs1 == x_rs2);
    unique case (size)
      2'd0:    ls_mis = 1'b0;
      2'd1:    ls_mis = ls_addr[0];
      2'd2:    ls_mis = |ls_addr[1:0];
      default: ls_mis = (XLEN == 32) || (|ls_addr[2:0]);
    endcase
    unique case (size)
      2'd0:    lane_mask = NB'(1) << ls_off;
      2'd1:    lane_mask = NB'(3) << ls_off;
      2'd2:    lane_mask = NB'(15) << ls_off;
      default: lane_mask = {NB{1'b1}} << ls_off;
    endcase
    mul_sum = acc_q + (mul_b_q[0] ? mul_a_q : '0);
  end

  // Next-state for the multiplier FSM and all registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    acc_d      = acc_q;
    rd_vld_d   = 1'b0;
    jmp_vld_d  = 1'b0;
    rden_d     = '0;
    wren_d     = '0;
    mis_d      = 1'b0;
    rd_d       = ex_rd;
    jmp_addr_d = ex_jmp_addr;
    mem_addr_d = ex_mem_addr;
    wrdata_d   = ex_mem_wrdata;

    if (state_q == MUL_BUSY) begin
      if (flush) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        acc_d   = mul_sum;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SW'(XLEN - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rd_d     = mul_sum;
          rd_vld_d = 1'b1;
        end
      end
    end else if (accept) begin
      case (op)
        5'd0:  begin rd_d = x_rs1 + opb;  rd_vld_d = 1'b1; end
        5'd1:  begin rd_d = x_rs1 - opb;  rd_vld_d = 1'b1; end
        5'd2:  begin rd_d = x_rs1 & opb;  rd_vld_d = 1'b1; end
        5'd3:  begin rd_d = x_rs1 | opb;  rd_vld_d = 1'b1; end
        5'd4:  begin rd_d = x_rs1 ^ opb;  rd_vld_d = 1'b1; end
        5'd5:  begin
          rd_d     = XLEN'($signed(x_rs1) < $signed(opb));
          rd_vld_d = 1'b1;
        end
        5'd6:  begin rd_d = XLEN'(x_rs1 < opb); rd_vld_d = 1'b1; end
        5'd7:  begin rd_d = x_rs1 << shamt; rd_vld_d = 1'b1; end
        5'd8:  begin rd_d = x_rs1 >> shamt; rd_vld_d = 1'b1; end
        5'd9:  begin rd_d = $signed(x_rs1) >>> shamt; rd_vld_d = 1'b1; end
        5'd10: begin rd_d = imm; rd_vld_d = 1'b1; end
        5'd11, 5'd12, 5'd13, 5'd14: begin
          jmp_addr_d = pc + imm;
          unique case (op)
            5'd11:   jmp_vld_d = br_eq;
            5'd12:   jmp_vld_d = !br_eq;
            5'd13:   jmp_vld_d = br_lt;
            default: jmp_vld_d = !br_lt;
          endcase
        end
        5'd15: begin rd_d = pc + XLEN'(4); rd_vld_d = 1'b1; end
        5'd16: begin
          rd_d       = pc + XLEN'(4);
          rd_vld_d   = 1'b1;
          jmp_addr_d = ls_addr & ~XLEN'(1);
          jmp_vld_d  = 1'b1;
        end
        5'd17, 5'd18: begin
          mem_addr_d = ls_addr;
          if (ls_mis) begin
            mis_d = 1'b1;
          end else if (op == 5'd17) begin
            rden_d = lane_mask;
          end else begin
            wren_d   = lane_mask;
            wrdata_d = x_rs2 << {ls_off, 3'b000};
          end
        end
        5'd19: begin
          // B is always x_rs2 for MUL, regardless of use_imm
          if (MUL_EN) begin
            state_d = MUL_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            mul_a_d = x_rs1;
            mul_b_d = x_rs2;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      acc_q         <= '0;
      ex_rd_vld     <= 1'b0;
      ex_rd         <= '0;
      ex_jmp_vld    <= 1'b0;
      ex_jmp_addr   <= '0;
      ex_mem_addr   <= '0;
      ex_mem_rden   <= '0;
      ex_mem_wren   <= '0;
      ex_mem_wrdata <= '0;
      ex_misalign   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      acc_q         <= acc_d;
      ex_rd_vld     <= rd_vld_d;
      ex_rd         <= rd_d;
      ex_jmp_vld    <= jmp_vld_d;
      ex_jmp_addr   <= jmp_addr_d;
      ex_mem_addr   <= mem_addr_d;
      ex_mem_rden   <= rden_d;
      ex_mem_wren   <= wren_d;
      ex_mem_wrdata <= wrdata_d;
      ex_misalign   <= mis_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus randomized
// single-cycle ops checked against a behavioural model, MUL, flush and reset.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_rdy, use_imm, flush;
  logic [4:0]  op;
  logic [1:0]  size;
  logic [31:0] x_rs1, x_rs2, imm, pc;
  logic        ex_rd_vld, ex_jmp_vld, ex_misalign;
  logic [31:0] ex_rd, ex_jmp_addr, ex_mem_addr, ex_mem_wrdata;
  logic [3:0]  ex_mem_rden, ex_mem_wren;

  logic        in_vld64, in_rdy64, use_imm64;
  logic [4:0]  op64;
  logic [1:0]  size64;
  logic [63:0] x_rs1_64, x_rs2_64, imm64, pc64;
  logic        ex_rd_vld64, ex_jmp_vld64, ex_misalign64;
  logic [63:0] ex_rd64, ex_jmp_addr64, ex_mem_addr64, ex_mem_wrdata64;
  logic [7:0]  ex_mem_rden64, ex_mem_wren64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_unit #(.XLEN(32), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .op(op),
    .use_imm(use_imm), .size(size), .x_rs1(x_rs1), .x_rs2(x_rs2), .imm(imm),
    .pc(pc), .flush(flush), .ex_rd_vld(ex_rd_vld), .ex_rd(ex_rd),
    .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr), .ex_mem_addr(ex_mem_addr),
    .ex_mem_rden(ex_mem_rden), .ex_mem_wren(ex_mem_wren),
    .ex_mem_wrdata(ex_mem_wrdata), .ex_misalign(ex_misalign)
  );

  exec_unit #(.XLEN(64), .MUL_EN(1'b0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld64), .in_rdy(in_rdy64), .op(op64),
    .use_imm(use_imm64), .size(size64), .x_rs1(x_rs1_64), .x_rs2(x_rs2_64),
    .imm(imm64), .pc(pc64), .flush(1'b0), .ex_rd_vld(ex_rd_vld64), .ex_rd(ex_rd64),
    .ex_jmp_vld(ex_jmp_vld64), .ex_jmp_addr(ex_jmp_addr64),
    .ex_mem_addr(ex_mem_addr64), .ex_mem_rden(ex_mem_rden64),
    .ex_mem_wren(ex_mem_wren64), .ex_mem_wrdata(ex_mem_wrdata64),
    .ex_misalign(ex_misalign64)
  );

  typedef struct packed {
    logic        rd_vld;
    logic [31:0] rd;
    logic        jmp_vld;
    logic [31:0] jmp_addr;
    logic [31:0] mem_addr;
    logic [3:0]  rden;
    logic [3:0]  wren;
    logic [31:0] wrdata;
    logic        mis;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model for one single-cycle op on the 32-bit unit
  function automatic exp_t model(input logic [4:0] o, input logic ui, input logic [1:0] sz,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im, input logic [31:0] p);
    exp_t e;
    logic [31:0] b;
    int nbytes, off, m;
    e = '0;
    b = ui ? im : r2;
    case (o)
      0: begin e.rd = r1 + b; e.rd_vld = 1; end
      1: begin e.rd = r1 - b; e.rd_vld = 1; end
      2: begin e.rd = r1 & b; e.rd_vld = 1; end
      3: begin e.rd = r1 | b; e.rd_vld = 1; end
      4: begin e.rd = r1 ^ b; e.rd_vld = 1; end
      5: begin e.rd = (int'(r1) < int'(b)) ? 32'd1 : 32'd0; e.rd_vld = 1; end
      6: begin e.rd = (r1 < b) ? 32'd1 : 32'd0; e.rd_vld = 1; end
      7: begin e.rd = r1 << (b % 32); e.rd_vld = 1; end
      8: begin e.rd = r1 >> (b % 32); e.rd_vld = 1; end
      9: begin e.rd = 32'(int'(r1) >>> (b % 32)); e.rd_vld = 1; end
      10: begin e.rd = im; e.rd_vld = 1; end
      11: begin e.jmp_vld = (r1 == r2); e.jmp_addr = p + im; end
      12: begin e.jmp_vld = (r1 != r2); e.jmp_addr = p + im; end
      13: begin e.jmp_vld = (int'(r1) < int'(r2)); e.jmp_addr = p + im; end
      14: begin e.jmp_vld = (int'(r1) >= int'(r2)); e.jmp_addr = p + im; end
      15: begin e.rd = p + 4; e.rd_vld = 1; end
      16: begin e.rd = p + 4; e.rd_vld = 1; e.jmp_vld = 1; e.jmp_addr = (r1 + im) & ~32'd1; end
      17, 18: begin
        e.mem_addr = r1 + im;
        nbytes = 1 << sz;
        off = int'(e.mem_addr % 4);
        if (sz == 3 || (e.mem_addr % nbytes) != 0) begin
          e.mis = 1;
        end else begin
          m = ((1 << nbytes) - 1) << off;
          if (o == 17) e.rden = m[3:0];
          else begin
            e.wren = m[3:0];
            e.wrdata = r2 << (8 * off);
          end
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [4:0] o, input logic ui, input logic [1:0] sz,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
    @(negedge clk);
    op = o; use_imm = ui; size = sz; x_rs1 = r1; x_rs2 = r2; imm = im; pc = p;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic issue64(input logic [4:0] o, input logic ui, input logic [1:0] sz,
                         input logic [63:0] r1, input logic [63:0] im);
    @(negedge clk);
    op64 = o; use_imm64 = ui; size64 = sz; x_rs1_64 = r1; imm64 = im;
    in_vld64 = 1'b1;
    @(posedge clk);
    #1;
    in_vld64 = 1'b0;
  endtask

  task automatic check_model(input exp_t e);
    chk("rd_vld", 64'(ex_rd_vld), 64'(e.rd_vld));
    if (e.rd_vld) chk("rd", 64'(ex_rd), 64'(e.rd));
    chk("jmp_vld", 64'(ex_jmp_vld), 64'(e.jmp_vld));
    if (e.jmp_vld) chk("jmp_addr", 64'(ex_jmp_addr), 64'(e.jmp_addr));
    chk("rden", 64'(ex_mem_rden), 64'(e.rden));
    chk("wren", 64'(ex_mem_wren), 64'(e.wren));
    if (e.wren != 0) chk("wrdata", 64'(ex_mem_wrdata), 64'(e.wrdata));
    if (e.rden != 0 || e.wren != 0) chk("mem_addr", 64'(ex_mem_addr), 64'(e.mem_addr));
    chk("misalign", 64'(ex_misalign), 64'(e.mis));
  endtask

  // Runs a MUL, perturbs inputs while busy, checks latency and product
  task automatic mul_check(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] prod;
    int cycles;
    prod = a * b;
    issue(5'd19, 1'($urandom), 2'd0, a, b, $urandom, 32'd0);
    x_rs1 = $urandom;
    x_rs2 = $urandom;
    cycles = 0;
    while (!ex_rd_vld && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("mul_latency", 64'(cycles), 64'd32);
    chk("mul_result", 64'(ex_rd), 64'(prod));
    chk("mul_rdy_back", 64'(in_rdy), 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [4:0] ro;
    int cycles, rdy_seen, vld_seen;

    rst_n = 1'b0; in_vld = 0; op = 0; use_imm = 0; size = 0; flush = 0;
    x_rs1 = 0; x_rs2 = 0; imm = 0; pc = 0;
    in_vld64 = 0; op64 = 0; use_imm64 = 0; size64 = 0;
    x_rs1_64 = 0; x_rs2_64 = 0; imm64 = 0; pc64 = 0;
    #12;
    chk("rst_rd_vld", 64'(ex_rd_vld), 64'd0);
    chk("rst_rd", 64'(ex_rd), 64'd0);
    chk("rst_jmp_vld", 64'(ex_jmp_vld), 64'd0);
    chk("rst_jmp_addr", 64'(ex_jmp_addr), 64'd0);
    chk("rst_mem_addr", 64'(ex_mem_addr), 64'd0);
    chk("rst_rden", 64'(ex_mem_rden), 64'd0);
    chk("rst_wren", 64'(ex_mem_wren), 64'd0);
    chk("rst_wrdata", 64'(ex_mem_wrdata), 64'd0);
    chk("rst_misalign", 64'(ex_misalign), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);

    // ADD wraps modulo 2^32
    issue(5'd0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("add_wrap_vld", 64'(ex_rd_vld), 64'd1);
    chk("add_wrap_rd", 64'(ex_rd), 64'd0);

    // BNE not taken / taken
    issue(5'd12, 1'b0, 2'd0, 32'd5, 32'd5, 32'h20, 32'h100);
    chk("bne_nt_vld", 64'(ex_jmp_vld), 64'd0);
    chk("bne_nt_rd_vld", 64'(ex_rd_vld), 64'd0);
    issue(5'd12, 1'b0, 2'd0, 32'd5, 32'd6, 32'h20, 32'h100);
    chk("bne_t_vld", 64'(ex_jmp_vld), 64'd1);
    chk("bne_t_addr", 64'(ex_jmp_addr), 64'h120);

    // STORE half aligned / misaligned
    issue(5'd18, 1'b0, 2'd1, 32'h1002, 32'hABCD, 32'd0, 32'd0);
    chk("sh_wren", 64'(ex_mem_wren), 64'hC);
    chk("sh_wrdata", 64'(ex_mem_wrdata), 64'hABCD_0000);
    chk("sh_mis", 64'(ex_misalign), 64'd0);
    issue(5'd18, 1'b0, 2'd1, 32'h1001, 32'hABCD, 32'd0, 32'd0);
    chk("sh_mis_wren", 64'(ex_mem_wren), 64'd0);
    chk("sh_mis_flag", 64'(ex_misalign), 64'd1);

    // Randomized single-cycle ops (MUL excluded) against the model
    for (int i = 0; i < 80; i++) begin
      ro = 5'($urandom_range(0, 31));
      if (ro == 5'd19) ro = 5'd20;
      issue(ro, 1'($urandom), 2'($urandom), $urandom, $urandom,
            (i % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom, $urandom);
      e = model(ro, use_imm, size, x_rs1, x_rs2, imm, pc);
      check_model(e);
    end

    // MUL 7*6 with a following ADD held on in_vld
    issue(5'd19, 1'b1, 2'd0, 32'd7, 32'd6, 32'd99, 32'd0);
    op = 5'd0; use_imm = 1'b0; x_rs1 = 32'd3; x_rs2 = 32'd4; in_vld = 1'b1;
    cycles = 0;
    rdy_seen = 0;
    while (!ex_rd_vld && cycles < 100) begin
      if (in_rdy) rdy_seen++;
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("mul76_latency", 64'(cycles), 64'd32);
    chk("mul76_rdy_busy", 64'(rdy_seen), 64'd0);
    chk("mul76_result", 64'(ex_rd), 64'd42);
    chk("mul76_rdy_back", 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    chk("add_after_mul_vld", 64'(ex_rd_vld), 64'd1);
    chk("add_after_mul_rd", 64'(ex_rd), 64'd7);

    for (int i = 0; i < 4; i++) mul_check($urandom, $urandom);

    // Flush in IDLE suppresses accept
    flush = 1'b1;
    issue(5'd0, 1'b0, 2'd0, 32'd1, 32'd2, 32'd0, 32'd0);
    flush = 1'b0;
    chk("flush_idle_vld", 64'(ex_rd_vld), 64'd0);

    // Flush mid-MUL
    issue(5'd19, 1'b0, 2'd0, 32'd3, 32'd5, 32'd0, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_mul_vld", 64'(ex_rd_vld), 64'd0);
    chk("flush_mul_rdy", 64'(in_rdy), 64'd1);
    vld_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ex_rd_vld) vld_seen++;
    end
    chk("flush_mul_no_vld", 64'(vld_seen), 64'd0);

    // Flush coinciding with the completion edge wins
    issue(5'd19, 1'b0, 2'd0, 32'd9, 32'd9, 32'd0, 32'd0);
    repeat (31) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_last_vld", 64'(ex_rd_vld), 64'd0);
    chk("flush_last_rdy", 64'(in_rdy), 64'd1);

    // Reset pulse mid-MUL clears outputs and discards the multiply
    issue(5'd0, 1'b0, 2'd0, 32'd5, 32'd6, 32'd0, 32'd0);
    chk("pre_rst_rd", 64'(ex_rd), 64'd11);
    issue(5'd19, 1'b0, 2'd0, 32'd12, 32'd12, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd", 64'(ex_rd), 64'd0);
    chk("rst_mid_rd_vld", 64'(ex_rd_vld), 64'd0);
    chk("rst_mid_rdy", 64'(in_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ex_rd_vld) vld_seen++;
    end
    chk("rst_mid_no_vld", 64'(vld_seen), 64'd0);

    // 64-bit instance (MUL disabled)
    issue64(5'd9, 1'b1, 2'd0, 64'h8000_0000_0000_0000, 64'd63);
    chk("sra64_rd", ex_rd64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sra64_vld", 64'(ex_rd_vld64), 64'd1);
    issue64(5'd17, 1'b0, 2'd3, 64'h8, 64'd0);
    chk("ld64_rden", 64'(ex_mem_rden64), 64'hFF);
    chk("ld64_rd_vld", 64'(ex_rd_vld64), 64'd0);
    issue64(5'd17, 1'b0, 2'd3, 64'hC, 64'd0);
    chk("ld64_mis_rden", 64'(ex_mem_rden64), 64'd0);
    chk("ld64_mis_flag", 64'(ex_misalign64), 64'd1);
    issue64(5'd19, 1'b0, 2'd0, 64'd3, 64'd0);
    chk("mul_off_vld", 64'(ex_rd_vld64), 64'd0);
    chk("mul_off_rdy", 64'(in_rdy64), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
